// File: rtl/ssd_display_arbiter.sv
// ---------------------------------------------------------------------------
// ssd_display_arbiter
//
// Shares one 4-digit seven-segment frame bus between three requesters:
//   requester 0 : lock FSM background display (preemptable at any time)
//   requester 1 : transient message (kept at least MIN_HOLD cycles)
//   requester 2 : transient message, highest priority (same hold rule)
// Every owner change passes through a one-cycle blank SWITCH state, and
// per-digit blinking is applied with a phase that restarts on each grant.
//
// Ports
//   clk            system clock
//   rst            synchronous, active-low reset
//   req[2:0]       level requests, bit 2 = highest priority
//   frame0..2      requester frames, 4 x 5-bit codes, [19:15] leftmost digit
//   blink0..2      per-digit blink masks, bit 3 = leftmost digit
//   grant[2:0]     one-hot current owner, 0 when idle or switching
//   done[2:0]      one-cycle pulse after grant[i] falls (not caused by reset)
//   ssd[19:0]      registered frame for the seven_segment driver
// ---------------------------------------------------------------------------
module ssd_display_arbiter #(
  parameter int BLINK_HALF = 50_000_000,
  parameter int MIN_HOLD   = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [19:0] frame0,
  input  logic [19:0] frame1,
  input  logic [19:0] frame2,
  input  logic [3:0]  blink0,
  input  logic [3:0]  blink1,
  input  logic [3:0]  blink2,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic [19:0] ssd
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE  = 2'd1,
    SWITCH = 2'd2
  } state_t;

  localparam logic [4:0]  BLANK_DIGIT = 5'b10011;
  localparam logic [19:0] BLANK_FRAME = {4{BLANK_DIGIT}};

  localparam int HW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [HW-1:0] HOLD_MAX   = HW'(MIN_HOLD);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  state_t        r_state;
  logic [1:0]    r_owner;
  logic [2:0]    r_grant;
  logic [2:0]    r_done;
  logic [19:0]   r_ssd;
  logic [HW-1:0] r_hold_cnt;
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;

  state_t        w_state_next;
  logic [1:0]    w_owner_next;
  logic [1:0]    w_win;
  logic          w_any;
  logic          w_hold_ok;
  logic          w_entry;
  logic [2:0]    w_grant_next;
  logic [19:0]   w_frame;
  logic [3:0]    w_mask;
  logic [19:0]   w_ssd_next;

  // Highest-priority requester; w_win is only meaningful when w_any is set.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_any = |req;
    w_win = 2'd0;
    if (req[2])      w_win = 2'd2;
    else if (req[1]) w_win = 2'd1;
  end

  // The background owner can always be displaced; transient owners only
  // after the hold counter has saturated.
  assign w_hold_ok = (r_owner == 2'd0) || (r_hold_cnt == HOLD_MAX);

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_next = SERVE;
          w_owner_next = w_win;
        end
      end
      SERVE: begin
        // Leave on preemption by a strictly higher requester or on release;
        // a release with other requests pending still goes through SWITCH.
        if (w_hold_ok && ((w_win > r_owner) || !req[r_owner])) begin
          w_state_next = w_any ? SWITCH : IDLE;
        end
      end
      SWITCH: begin
        if (w_any) begin
          w_state_next = SERVE;
          w_owner_next = w_win;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_entry      = (w_state_next == SERVE) && (r_state != SERVE);
  assign w_grant_next = (w_state_next == SERVE) ? (3'b001 << w_owner_next) : 3'b000;

  // Output frame is built from the current owner and phase; frames and masks
  // are used live, so an owner's edits show up one cycle later.
  always_comb begin
    w_frame = frame0;
    w_mask  = blink0;
    case (r_owner)
      2'd1: begin
        w_frame = frame1;
        w_mask  = blink1;
      end
      2'd2: begin
        w_frame = frame2;
        w_mask  = blink2;
      end
      default: begin
        w_frame = frame0;
        w_mask  = blink0;
      end
    endcase

    w_ssd_next = BLANK_FRAME;
    if (r_state == SERVE) begin
      for (int k = 0; k < 4; k++) begin
        w_ssd_next[5*k +: 5] = (w_mask[k] && r_phase) ? BLANK_DIGIT : w_frame[5*k +: 5];
      end
    end
  end

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_owner     <= 2'd0;
      r_grant     <= 3'b000;
      r_done      <= 3'b000;
      r_ssd       <= BLANK_FRAME;
      r_hold_cnt  <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      r_grant <= w_grant_next;
      r_done  <= r_grant & ~w_grant_next;
      r_ssd   <= w_ssd_next;

      if (w_entry) begin
        r_hold_cnt <= '0;
      end else if ((r_state == SERVE) && (r_hold_cnt != HOLD_MAX)) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end

      // Restarting on entry puts every new owner in the on phase.
      if (w_entry) begin
        r_blink_cnt <= '0;
        r_phase     <= 1'b0;
      end else if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign grant = r_grant;
  assign done  = r_done;
  assign ssd   = r_ssd;

endmodule
